// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line idle level and
// the default bit period used by the TX drain stage and the bit timer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_t;

    // An idle UART line rests at mark (high).
    localparam logic UART_IDLE_LVL = 1'b1;

    // 100 MHz system clock / 115200 baud.
    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

    // Payload width; matches the upstream FIFO data width.
    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last clock of each bit so the owning FSM can advance on the boundary.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    localparam int CNT_W       = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             bit_tick_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear beats load beats counting; wrap to zero on the boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = en_i && !clear_i && !load_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmit drain stage: pops bytes from a 1-cycle-latency FIFO read port
// and serialises each as start + LSB-first data + stop bit(s) on tx_serial_o.
// All outputs are flops loaded from the next-state decode, so nothing on an
// output depends combinationally on an input.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_en_o,
    input  logic [7:0]  fifo_data_i,
    output logic        tx_serial_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] byte_cnt_o
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);

    tx_state_t            state_q;
    tx_state_t            state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [IDX_W-1:0]     bit_idx_d;
    logic                 tx_q;
    logic                 tx_d;
    logic                 rd_en_q;
    logic                 rd_en_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 done_q;
    logic                 done_d;
    logic [15:0]          byte_cnt_q;
    logic [15:0]          byte_cnt_d;

    logic                 timer_en;
    logic                 bit_tick;

    // The timer only runs while a bit is on the line; it sits at zero otherwise
    // so every START begins with a full bit period.
    assign timer_en = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (!timer_en),
        .load_i     (1'b0),
        .load_val_i ({TMR_W{1'b0}}),
        .en_i       (timer_en),
        .bit_tick_o (bit_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. enable_i and fifo_empty_i only matter in IDLE, so a
    // frame in progress always completes untouched.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable_i && !fifo_empty_i) state_d = REQ;
            REQ:     state_d = LATCH;
            LATCH:   state_d = START;
            START:   if (bit_tick) state_d = DATA;
            DATA:    if (bit_tick && (bit_idx_q == LAST_DATA_IDX)) state_d = STOP;
            STOP:    if (bit_tick && (bit_idx_q == LAST_STOP_IDX)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture FIFO data one cycle after the read strobe,
    // shift out LSB first, and reuse the bit index to count stop bits.
    always_comb begin
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        unique case (state_q)
            LATCH: begin
                shift_d   = DATA_BITS'(fifo_data_i);
                bit_idx_d = '0;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = (bit_idx_q == LAST_DATA_IDX) ? '0 : bit_idx_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    bit_idx_d = (bit_idx_q == LAST_STOP_IDX) ? '0 : bit_idx_q + 1'b1;
                end
            end
            default: bit_idx_d = '0;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up
    // with the state they describe.
    always_comb begin
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = UART_IDLE_LVL;
        endcase
        rd_en_d    = (state_d == REQ);
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == STOP) && (state_d == IDLE);
        byte_cnt_d = byte_cnt_q + 16'(done_d);
    end

    // Datapath and output registers; reset drives the line back to idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            bit_idx_q  <= '0;
            tx_q       <= UART_IDLE_LVL;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign tx_serial_o  = tx_q;
    assign fifo_rd_en_o = rd_en_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign byte_cnt_o   = byte_cnt_q;

endmodule
